input_edge_timestamper: RTL

- Receive-side counterpart of the output pulse/pattern driver.
- Watches one deserialized input pin (SERDES parallel word, LSB = earliest sample) in the EVR clock domain and detects rising edges.
- Timestamps each edge with heartbeat-relative coarse word count plus fine bit position, and queues the events in a small FIFO for a downstream consumer (CSR reader or event logger).

---
 rtl/input_edge_timestamper_pkg.sv | 39 +++
 rtl/input_edge_timestamper_event_fifo.sv | 48 ++++
 rtl/input_edge_timestamper.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/input_edge_timestamper_pkg.sv
// Shared definitions for the input edge timestamper and its event consumers.
// Event layout, LSB first: fine, coarse, multiEdge, then polarity when
// INPUT_EDGE_TIMESTAMPER_FALLING_EN is defined.
package input_edge_timestamper_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_HOLDOFF = 2'd2
    } state_t;

`ifdef INPUT_EDGE_TIMESTAMPER_FALLING_EN
    localparam int POLARITY_BITS = 1;
`else
    localparam int POLARITY_BITS = 0;
`endif

    function automatic int fine_width(input int serdes_width);
        return (serdes_width > 1) ? $clog2(serdes_width) : 1;
    endfunction

    function automatic int event_width(input int coarse_width, input int fine_w);
        return coarse_width + fine_w + 1 + POLARITY_BITS;
    endfunction

    // Field offsets within eventData, for consumers that unpack events.
    function automatic int coarse_lsb(input int fine_w);
        return fine_w;
    endfunction

    function automatic int multi_edge_bit(input int coarse_width, input int fine_w);
        return fine_w + coarse_width;
    endfunction

    function automatic int polarity_bit(input int coarse_width, input int fine_w);
        return fine_w + coarse_width + 1;
    endfunction

endpackage

// File: rtl/input_edge_timestamper_event_fifo.sv
// Synchronous first-word-fall-through FIFO. A write while full is accepted
// when a read happens in the same cycle.
module input_edge_timestamper_event_fifo #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_wr,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_rd,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_empty,
    output logic                  o_full
);
    localparam int DEPTH = 1 << ADDRESS_WIDTH;

    logic [DATA_WIDTH-1:0]  r_mem [DEPTH];
    logic [ADDRESS_WIDTH:0] r_wr_ptr;
    logic [ADDRESS_WIDTH:0] r_rd_ptr;
    logic                   w_rd_ok;
    logic                   w_wr_ok;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[ADDRESS_WIDTH] != r_rd_ptr[ADDRESS_WIDTH]) &&
                     (r_wr_ptr[ADDRESS_WIDTH-1:0] == r_rd_ptr[ADDRESS_WIDTH-1:0]);
    assign w_rd_ok = i_rd & ~o_empty;
    assign w_wr_ok = i_wr & (~o_full | w_rd_ok);
    // Head is forced to zero when empty so the output is defined after reset.
    assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr[ADDRESS_WIDTH-1:0]];

    // Read/write pointers with one wrap bit for full/empty distinction.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge i_clk) begin
        if (w_wr_ok) r_mem[r_wr_ptr[ADDRESS_WIDTH-1:0]] <= i_data;
    end

endmodule

// File: rtl/input_edge_timestamper.sv
// Rising-edge timestamper for one deserialized input pin in the EVR domain.
// Pipeline: input word register -> detection register -> event FIFO.
// Define INPUT_EDGE_TIMESTAMPER_FALLING_EN to also capture falling edges
// and add a polarity bit as the event MSB.
//
// state     | meaning
// S_IDLE    | capture disabled
// S_WAIT    | armed, the next word with an edge produces an event
// S_HOLDOFF | ignoring edges until the holdoff counter reaches zero
module input_edge_timestamper
    import input_edge_timestamper_pkg::*;
#(
    parameter  int SERDES_WIDTH       = 4,
    parameter  int COARSE_WIDTH       = 24,
    parameter  int FIFO_ADDRESS_WIDTH = 4,
    localparam int FINE_WIDTH         = fine_width(SERDES_WIDTH),
    localparam int EVENT_WIDTH        = event_width(COARSE_WIDTH, FINE_WIDTH)
) (
    input  logic                    evrClk,
    input  logic                    evrReset_n,
    input  logic [SERDES_WIDTH-1:0] serdesPattern,
    input  logic                    evrHBstrobe,
    input  logic                    enable,
    input  logic [15:0]             holdoffWords,
    output logic                    eventValid,
    input  logic                    eventReady,
    output logic [EVENT_WIDTH-1:0]  eventData,
    output logic [15:0]             dropCount
);
    logic [SERDES_WIDTH-1:0] r_word;
    logic                    r_hb;
    logic                    r_en;
    logic                    r_prev;
    logic [COARSE_WIDTH-1:0] r_coarse;
    logic [15:0]             r_holdoff;
    state_t                  r_state;
    state_t                  w_next_state;
    logic                    w_load_holdoff;
    logic                    r_det_valid;
    logic [EVENT_WIDTH-1:0]  r_det_data;
    logic [15:0]             r_drop;

    logic [SERDES_WIDTH:0]   w_ext;
    logic [SERDES_WIDTH-1:0] w_rise;
    logic [SERDES_WIDTH-1:0] w_edges;
    logic [FINE_WIDTH-1:0]   w_fine;
    logic                    w_multi;
    logic [COARSE_WIDTH-1:0] w_coarse;
    logic                    w_capture;
    logic [EVENT_WIDTH-1:0]  w_event_data;
    logic                    w_fifo_empty;
    logic                    w_fifo_full;
    logic                    w_read;
    logic                    w_drop;

    // Bit i of w_ext+1 is sample i; w_ext[0] is the previous word's last sample.
    assign w_ext  = {r_word, r_prev};
    assign w_rise = w_ext[SERDES_WIDTH:1] & ~w_ext[SERDES_WIDTH-1:0];

`ifdef INPUT_EDGE_TIMESTAMPER_FALLING_EN
    logic [SERDES_WIDTH-1:0] w_fall;
    logic                    w_polarity;
    assign w_fall       = ~w_ext[SERDES_WIDTH:1] & w_ext[SERDES_WIDTH-1:0];
    assign w_edges      = w_rise | w_fall;
    assign w_polarity   = w_rise[w_fine];
    assign w_event_data = {w_polarity, w_multi, w_coarse, w_fine};
`else
    assign w_edges      = w_rise;
    assign w_event_data = {w_multi, w_coarse, w_fine};
`endif

    assign w_multi   = (w_edges & (w_edges - SERDES_WIDTH'(1))) != '0;
    assign w_coarse  = r_hb ? '0 : r_coarse;
    assign w_capture = (r_state == S_WAIT) && (|w_edges);

    // Lowest-index edge gives the fine timestamp.
    always_comb begin
        w_fine = '0;
        for (int i = SERDES_WIDTH - 1; i >= 0; i--) begin
            if (w_edges[i]) w_fine = FINE_WIDTH'(i);
        end
    end

    // Input word register; word resets to ones so no edge appears at reset release.
    always_ff @(posedge evrClk or negedge evrReset_n) begin
        if (!evrReset_n) begin
            r_word <= '1;
            r_hb   <= 1'b0;
            r_en   <= 1'b0;
            r_prev <= 1'b1;
        end else begin
            r_word <= serdesPattern;
            r_hb   <= evrHBstrobe;
            r_en   <= enable;
            r_prev <= r_word[SERDES_WIDTH-1];
        end
    end

    // Heartbeat-relative coarse word counter, saturating.
    always_ff @(posedge evrClk or negedge evrReset_n) begin
        if (!evrReset_n) begin
            r_coarse <= '0;
        end else if (r_hb) begin
            r_coarse <= COARSE_WIDTH'(1);
        end else if (r_coarse != '1) begin
            r_coarse <= r_coarse + COARSE_WIDTH'(1);
        end
    end

    // State register and holdoff down-counter.
    always_ff @(posedge evrClk or negedge evrReset_n) begin
        if (!evrReset_n) begin
            r_state   <= S_IDLE;
            r_holdoff <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_load_holdoff) begin
                r_holdoff <= holdoffWords - 16'd1;
            end else if (r_state == S_HOLDOFF && r_holdoff != '0) begin
                r_holdoff <= r_holdoff - 16'd1;
            end
        end
    end

    // Next-state logic; dropping enable overrides every state.
    always_comb begin
        w_next_state   = r_state;
        w_load_holdoff = 1'b0;
        if (!r_en) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    w_next_state = S_WAIT;
                S_WAIT: begin
                    if (w_capture && holdoffWords != '0) begin
                        w_next_state   = S_HOLDOFF;
                        w_load_holdoff = 1'b1;
                    end
                end
                S_HOLDOFF: if (r_holdoff == '0) w_next_state = S_WAIT;
                default:   w_next_state = S_IDLE;
            endcase
        end
    end

    // Detection register feeding the FIFO write port.
    always_ff @(posedge evrClk or negedge evrReset_n) begin
        if (!evrReset_n) begin
            r_det_valid <= 1'b0;
            r_det_data  <= '0;
        end else begin
            r_det_valid <= w_capture;
            r_det_data  <= w_event_data;
        end
    end

    assign w_read = ~w_fifo_empty & eventReady;
    assign w_drop = r_det_valid & w_fifo_full & ~w_read;

    // Saturating count of events lost to a full FIFO.
    always_ff @(posedge evrClk or negedge evrReset_n) begin
        if (!evrReset_n) begin
            r_drop <= '0;
        end else if (w_drop && r_drop != 16'hFFFF) begin
            r_drop <= r_drop + 16'd1;
        end
    end

    input_edge_timestamper_event_fifo #(
        .DATA_WIDTH    (EVENT_WIDTH),
        .ADDRESS_WIDTH (FIFO_ADDRESS_WIDTH)
    ) u_event_fifo (
        .i_clk   (evrClk),
        .i_rst_n (evrReset_n),
        .i_wr    (r_det_valid),
        .i_data  (r_det_data),
        .i_rd    (eventReady),
        .o_data  (eventData),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    assign eventValid = ~w_fifo_empty;
    assign dropCount  = r_drop;

endmodule
